// File: rtl/pipeline_hazard_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if: pipeline-to-hazard-controller bundle       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  logic             MemErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, StallCnt, FlushCnt, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, StallCnt, FlushCnt, MemErr
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl: RV32I forwarding, stall/flush sequencing     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int BR_PENALTY  = 0,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_BR_FLUSH = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int               TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [3:0]       BR_LOAD  = 4'(BR_PENALTY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       br_cnt_q, br_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic       mem_wait, in_br, load_use;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic [4:0] rd_m, input logic wr_m,
    input logic [4:0] rd_w, input logic wr_w
  );
    if (wr_m && rd_m != 5'd0 && rd_m == rs)
      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

  assign mem_wait = hz.MemReqM && !hz.MemReadyM;
  assign load_use = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  // A paused branch penalty survives a memory wait in br_cnt_q.
  assign in_br = (state_q == ST_BR_FLUSH) ||
                 ((state_q == ST_MEM_WAIT) && (br_cnt_q != 4'd0));

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    state_d   = ST_RUN;
    br_cnt_d  = br_cnt_q;
    to_cnt_d  = '0;
    mem_err_d = mem_err_q;
    if (mem_wait) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      flush_w  = 1'b1;
      state_d  = ST_MEM_WAIT;
      to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_d == TO_LIMIT)
        mem_err_d = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      if (BR_PENALTY > 0) begin
        br_cnt_d = BR_LOAD;
        state_d  = ST_BR_FLUSH;
      end else begin
        br_cnt_d = 4'd0;
      end
    end else begin
      if (in_br) begin
        flush_d  = 1'b1;
        br_cnt_d = br_cnt_q - 4'd1;
        state_d  = (br_cnt_q == 4'd1) ? ST_RUN : ST_BR_FLUSH;
      end
      if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = (stall_f && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_d && flush_cnt_q != CNT_MAX) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      br_cnt_q    <= 4'd0;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Reset gates the combinational outputs so they drop the instant rst rises.
  assign hz.ForwardAE = rst ? 2'b00 : fwd_a;
  assign hz.ForwardBE = rst ? 2'b00 : fwd_b;
  assign hz.StallF    = stall_f & ~rst;
  assign hz.StallD    = stall_d & ~rst;
  assign hz.StallE    = stall_e & ~rst;
  assign hz.StallM    = stall_m & ~rst;
  assign hz.FlushD    = flush_d & ~rst;
  assign hz.FlushE    = flush_e & ~rst;
  assign hz.FlushW    = flush_w & ~rst;
  assign hz.StallCnt  = stall_cnt_q;
  assign hz.FlushCnt  = flush_cnt_q;
  assign hz.MemErr    = mem_err_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [3:0]       st;
    logic [2:0]       fl;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] m_scnt = '0;
  logic [CNT_W-1:0] m_fcnt = '0;
  logic             m_err  = 1'b0;
  logic [19:0]      all_outs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .BR_PENALTY (2),
    .MEM_TIMEOUT(8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  assign all_outs = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                     hz.FlushD, hz.FlushE, hz.FlushW, hz.StallCnt, hz.FlushCnt, hz.MemErr};

  // Scoreboard consumer: one queued expectation per driven cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      checks += 7;
      if (hz.ForwardAE !== e.fa) begin
        errors++; $display("FAIL fwdA t=%0t: got %b want %b", $time, hz.ForwardAE, e.fa);
      end
      if (hz.ForwardBE !== e.fb) begin
        errors++; $display("FAIL fwdB t=%0t: got %b want %b", $time, hz.ForwardBE, e.fb);
      end
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM} !== e.st) begin
        errors++; $display("FAIL stallFDEM t=%0t: got %b want %b", $time,
                           {hz.StallF, hz.StallD, hz.StallE, hz.StallM}, e.st);
      end
      if ({hz.FlushD, hz.FlushE, hz.FlushW} !== e.fl) begin
        errors++; $display("FAIL flushDEW t=%0t: got %b want %b", $time,
                           {hz.FlushD, hz.FlushE, hz.FlushW}, e.fl);
      end
      if (hz.StallCnt !== e.scnt) begin
        errors++; $display("FAIL StallCnt t=%0t: got %0d want %0d", $time, hz.StallCnt, e.scnt);
      end
      if (hz.FlushCnt !== e.fcnt) begin
        errors++; $display("FAIL FlushCnt t=%0t: got %0d want %0d", $time, hz.FlushCnt, e.fcnt);
      end
      if (hz.MemErr !== e.err) begin
        errors++; $display("FAIL MemErr t=%0t: got %b want %b", $time, hz.MemErr, e.err);
      end
    end
  end

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic step(input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] st, input logic [2:0] fl);
    exp_t e;
    e = '{fa: fa, fb: fb, st: st, fl: fl, scnt: m_scnt, fcnt: m_fcnt, err: m_err};
    sb.push_back(e);
    @(negedge clk);
    if (st[3] && m_scnt != CNT_MAX) m_scnt = m_scnt + 1'b1;
    if (fl[2] && m_fcnt != CNT_MAX) m_fcnt = m_fcnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE  = 5'd0; hz.RdM  = 5'd0; hz.RdW  = 5'd0;
    hz.ResultSrcE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd7; hz.Rs1E = 5'd7; hz.PCSrcE = 1'b1;
    #12;
    checks++;
    if (all_outs !== 20'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_forwarding();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
    step(2'b10, 2'b00, 4'b0000, 3'b000);
    hz.RegWriteM = 1'b0;
    step(2'b01, 2'b00, 4'b0000, 3'b000);
    hz.RegWriteM = 1'b1; hz.RdM = 5'd0; hz.RdW = 5'd0; hz.Rs1E = 5'd0;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    hz.RdM = 5'd9; hz.RdW = 5'd12; hz.Rs1E = 5'd12; hz.Rs2E = 5'd9;
    step(2'b01, 2'b10, 4'b0000, 3'b000);
    hz.RegWriteW = 1'b0;
    step(2'b00, 2'b10, 4'b0000, 3'b000);
    clear_inputs();
  endtask

  task automatic test_load_use();
    hz.ResultSrcE = 1'b1; hz.RdE = 5'd3; hz.Rs2D = 5'd3;
    step(2'b00, 2'b00, 4'b1100, 3'b010);
    hz.ResultSrcE = 1'b0;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    hz.ResultSrcE = 1'b1; hz.RdE = 5'd17; hz.Rs1D = 5'd17; hz.Rs2D = 5'd1;
    step(2'b00, 2'b00, 4'b1100, 3'b010);
    hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    hz.ResultSrcE = 1'b0; hz.RdE = 5'd17; hz.Rs1D = 5'd17;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    clear_inputs();
  endtask

  task automatic test_branch();
    hz.PCSrcE = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b110);
    hz.PCSrcE = 1'b0;
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_mem_wait();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    repeat (4) step(2'b00, 2'b00, 4'b1111, 3'b001);
    hz.MemReadyM = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    clear_inputs();
    step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_back_to_back();
    hz.PCSrcE = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b110);
    hz.PCSrcE = 1'b0;
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    hz.PCSrcE = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b110);
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    repeat (2) step(2'b00, 2'b00, 4'b1111, 3'b001);
    hz.MemReadyM = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    clear_inputs();
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_timeout();
    hz.MemReqM = 1'b1;
    for (int n = 0; n < 2; n++) begin
      hz.MemReadyM = 1'b0;
      repeat (7) step(2'b00, 2'b00, 4'b1111, 3'b001);
      hz.MemReadyM = 1'b1;
      step(2'b00, 2'b00, 4'b0000, 3'b000);
    end
    hz.MemReadyM = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) m_err = 1'b1;
      step(2'b00, 2'b00, 4'b1111, 3'b001);
    end
    hz.MemReadyM = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    clear_inputs();
    step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_async_reset();
    hz.PCSrcE = 1'b1;
    step(2'b00, 2'b00, 4'b0000, 3'b110);
    hz.PCSrcE = 1'b0;
    step(2'b00, 2'b00, 4'b0000, 3'b100);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== 20'd0) begin
      errors++; $display("FAIL rst_mid_br: got %h want 0", all_outs);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    m_scnt = '0; m_fcnt = '0; m_err = 1'b0;
    @(posedge clk);
    #1;
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    repeat (2) step(2'b00, 2'b00, 4'b1111, 3'b001);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== 20'd0) begin
      errors++; $display("FAIL rst_mid_mem: got %h want 0", all_outs);
    end
    @(negedge clk);
    clear_inputs();
    #2 rst = 1'b0;
    m_scnt = '0; m_fcnt = '0; m_err = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step(2'b00, 2'b00, 4'b0000, 3'b000);
  endtask

  task automatic test_saturation();
    hz.ResultSrcE = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
    repeat (20) step(2'b00, 2'b00, 4'b1100, 3'b010);
    clear_inputs();
    step(2'b00, 2'b00, 4'b0000, 3'b000);
    checks++;
    if (hz.StallCnt !== 4'd15) begin
      errors++; $display("FAIL stallcnt_sat: got %0d want 15", hz.StallCnt);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_saturation();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline.
- Decides forwarding selects for the E-stage ALU operands.
- Sequences stalls and flushes of the F/D/E/M/W pipeline registers for load-use hazards, taken branches, a configurable extra branch penalty and multi-cycle data-memory waits.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
BR_PENALTY, 0, extra cycles FlushD held after the taken-branch cycle (0..15).
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before mem_err sets (>=2).
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
Rs1D  in  5  rs1 of instruction in D
Rs2D  in  5  rs2 of instruction in D
Rs1E  in  5  rs1 of instruction in E
Rs2E  in  5  rs2 of instruction in E
RdE  in  5  destination of instruction in E
RdM  in  5  destination of instruction in M
RdW  in  5  destination of instruction in W
ResultSrcE  in  1  instruction in E is a load
RegWriteM  in  1  M instruction writes register file
RegWriteW  in  1  W instruction writes register file
PCSrcE  in  1  branch/jump taken, resolved in E
MemReqM  in  1  M instruction accesses data memory
MemReadyM  in  1  data memory completes access this cycle
ForwardAE  out  2  00 RD1E, 10 ALUResultM, 01 ResultW
ForwardBE  out  2  same encoding for RD2E
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register to bubble
FlushE  out  1  clear D/E register to bubble
FlushW  out  1  clear M/W register to bubble
StallCnt  out  CNT_W  stall cycles counted
FlushCnt  out  CNT_W  FlushD cycles counted
MemErr  out  1  sticky memory-timeout flag

Behaviour:
Reset (rst=1, async):
- State=RUN; BR counter, timeout counter, StallCnt, FlushCnt and MemErr all 0.
- All stall/flush outputs and ForwardAE/BE forced 0 while rst is high.

Forwarding (combinational, every non-reset cycle, independent of state):
- ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1W-match, i.e. RdW==Rs1E.
- Else ForwardAE=00.
- M has priority over W. ForwardBE uses the same rules with Rs2E.

States: RUN, BR_FLUSH, MEM_WAIT. Outputs are Mealy (state + inputs), evaluated in priority order.
1. Memory wait (any state): MemReqM && !MemReadyM.
   - StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0.
   - Next state=MEM_WAIT; the BR_FLUSH counter is paused and retained.
2. Taken branch: PCSrcE=1.
   - FlushD=1, FlushE=1.
   - If BR_PENALTY>0: load counter=BR_PENALTY, next state=BR_FLUSH (a branch seen in BR_FLUSH restarts the counter).
   - If BR_PENALTY=0: next state=RUN.
3. BR_FLUSH without branch: FlushD=1, counter decrements; at counter==1, next state=RUN.
4. Load-use: ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
   - StallF=1, StallD=1, FlushE=1, for exactly one cycle.
   - Evaluated in RUN and BR_FLUSH.
- MEM_WAIT exit: the cycle MemReadyM=1 has no stall; rules 2–4 are applied as in the state being resumed (RUN, or BR_FLUSH if the counter is nonzero).
- Memory timeout: the timeout counter increments each MEM_WAIT cycle and clears on exit. On reaching MEM_TIMEOUT, MemErr is set and sticky until reset; stalls continue, with no forced exit.
- StallCnt: +1 each cycle StallF=1. FlushCnt: +1 each cycle FlushD=1. Both saturate at all-ones and never wrap.
- Reset mid-sequence: immediate return to RUN, counters and MemErr cleared, outputs 0 in the same cycle rst rises.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01. Then RdM=RdW=0 -> ForwardAE=00.
- Load-use: ResultSrcE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle, StallCnt 0->1. RdE=0 -> no stall.
- Branch with BR_PENALTY=2: PCSrcE pulse -> cycle0 FlushD=FlushE=1; cycles1–2 FlushD=1 only; cycle3 RUN with FlushD=0; FlushCnt=3.
- Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles then 1 -> 4 cycles of StallF/D/E/M=1 and FlushW=1, then 0 on the ready cycle; StallCnt +4. Repeat with a taken branch arriving mid BR_FLUSH: the counter resumes after the wait.
- Timeout with MEM_TIMEOUT=8: MemReadyM held 0 -> MemErr=1 after 8 wait cycles; it stays 1 after MemReadyM=1 and clears only on rst.
- Async reset: assert rst mid BR_FLUSH and mid MEM_WAIT, off clock edge -> all outputs 0 immediately. After release, state is RUN and counters are 0. Set CNT_W=4 and stall 20 cycles -> StallCnt saturates at 15.
